// File: rtl/ahb_tty_fifo.sv
// ahb_tty_fifo: AHB-Lite console slave. CPU byte writes are queued in a
// circular TX FIFO and drained through a valid/ready byte stream. Writing the
// stop character latches a sticky stop request. A DATA write into a full FIFO
// stalls the bus until a slot frees.
module ahb_tty_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter logic [7:0]  STOP_CHAR  = 8'h0D
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [3:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        stop_req,
  output logic        irq
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2 + 1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};

  // Register selects (HADDR[3:2]).
  localparam logic [1:0] SEL_DATA   = 2'd0;
  localparam logic [1:0] SEL_STATUS = 2'd1;
  localparam logic [1:0] SEL_CTRL   = 2'd2;

  // Response sequencer: the second cycle of an ERROR response.
  typedef enum logic [0:0] {
    RSP_OK   = 1'b0,
    RSP_ERR2 = 1'b1
  } rsp_state_e;

  // Pending data phase captured from the address phase.
  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_write_q, dp_write_d;
  logic                  dp_err_q,   dp_err_d;
  logic [1:0]            dp_sel_q,   dp_sel_d;
  rsp_state_e            rsp_q,      rsp_d;

  // Control / sticky state.
  logic                  irq_en_q,   irq_en_d;
  logic                  stop_req_q, stop_req_d;

  // FIFO storage.
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q,  count_d;
  logic [7:0]            mem_q [DEPTH];
  logic [7:0]            mem_d [DEPTH];

  // Combinational helpers.
  logic        addr_err_s;
  logic        empty_s;
  logic        full_s;
  logic        push_s;
  logic        pop_s;
  logic        stop_set_s;
  logic        hreadyout_s;
  logic        hresp_s;
  logic [31:0] hrdata_s;
  logic [31:0] status_s;
  logic [7:0]  wbyte_s;

  // Bits of the bus that carry no meaning for this slave.
  logic unused_s;
  assign unused_s = ^{HWDATA[31:8], HTRANS[0]};

  assign empty_s = (count_q == CNT_ZERO);
  assign full_s  = (count_q == FULL_CNT);
  assign pop_s   = ~empty_s & tx_ready;
  assign wbyte_s = HWDATA[7:0];

  // Address-phase legality: bad offset, oversize, or misaligned access.
  always_comb begin
    addr_err_s = 1'b0;
    if (HADDR[3:2] == 2'd3) begin
      addr_err_s = 1'b1;
    end else if (HSIZE > 3'd2) begin
      addr_err_s = 1'b1;
    end else if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) begin
      addr_err_s = 1'b1;
    end else if ((HSIZE == 3'd1) && HADDR[0]) begin
      addr_err_s = 1'b1;
    end else begin
      addr_err_s = 1'b0;
    end
  end

  // Capture a new address phase whenever the bus advances.
  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_err_d   = dp_err_q;
    dp_sel_d   = dp_sel_q;
    if (HREADY) begin
      dp_valid_d = HSEL & HTRANS[1];
      dp_write_d = HWRITE;
      dp_err_d   = addr_err_s;
      dp_sel_d   = HADDR[3:2];
    end else begin
      dp_valid_d = dp_valid_q;
    end
  end

  // STATUS word: empty, full, stop flag and occupancy count.
  always_comb begin
    status_s                   = 32'h0000_0000;
    status_s[0]                = empty_s;
    status_s[1]                = full_s;
    status_s[2]                = stop_req_q;
    status_s[DEPTH_LOG2+8:8]   = count_q;
  end

  // Data-phase response FSM: read mux, write side effects, wait and error.
  always_comb begin
    hreadyout_s = 1'b1;
    hresp_s     = 1'b0;
    hrdata_s    = 32'h0000_0000;
    rsp_d       = rsp_q;
    push_s      = 1'b0;
    stop_set_s  = 1'b0;
    irq_en_d    = irq_en_q;
    case (rsp_q)
      RSP_ERR2: begin
        hreadyout_s = 1'b1;
        hresp_s     = 1'b1;
        rsp_d       = RSP_OK;
      end
      RSP_OK: begin
        if (!dp_valid_q) begin
          rsp_d = RSP_OK;
        end else if (dp_err_q) begin
          hreadyout_s = 1'b0;
          hresp_s     = 1'b1;
          rsp_d       = RSP_ERR2;
        end else if (dp_write_q) begin
          case (dp_sel_q)
            SEL_DATA: begin
              if (wbyte_s == STOP_CHAR) begin
                stop_set_s = 1'b1;
              end else if (stop_req_q) begin
                push_s = 1'b0;           // console closed: drop silently
              end else if (!full_s) begin
                push_s = 1'b1;
              end else if (pop_s) begin
                push_s = 1'b1;           // slot frees this cycle
              end else begin
                hreadyout_s = 1'b0;      // full: stall the CPU
              end
            end
            SEL_CTRL: begin
              irq_en_d = HWDATA[0];
            end
            default: begin
              irq_en_d = irq_en_q;       // STATUS is read-only
            end
          endcase
        end else begin
          case (dp_sel_q)
            SEL_STATUS: hrdata_s = status_s;
            SEL_CTRL:   hrdata_s = {31'h0000_0000, irq_en_q};
            default:    hrdata_s = 32'h0000_0000;
          endcase
        end
      end
      default: begin
        rsp_d = RSP_OK;
      end
    endcase
  end

  // Sticky stop request.
  always_comb begin
    if (stop_set_s) begin
      stop_req_d = 1'b1;
    end else begin
      stop_req_d = stop_req_q;
    end
  end

  // FIFO pointers, occupancy and storage update.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = wbyte_s;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_err_q   <= 1'b0;
      dp_sel_q   <= 2'd0;
      rsp_q      <= RSP_OK;
      irq_en_q   <= 1'b0;
      stop_req_q <= 1'b0;
      wr_ptr_q   <= {DEPTH_LOG2{1'b0}};
      rd_ptr_q   <= {DEPTH_LOG2{1'b0}};
      count_q    <= CNT_ZERO;
      mem_q      <= '{default: 8'h00};
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_err_q   <= dp_err_d;
      dp_sel_q   <= dp_sel_d;
      rsp_q      <= rsp_d;
      irq_en_q   <= irq_en_d;
      stop_req_q <= stop_req_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  assign HREADYOUT = hreadyout_s;
  assign HRESP     = hresp_s;
  assign HRDATA    = hrdata_s;
  assign tx_valid  = ~empty_s;
  assign tx_data   = empty_s ? 8'h00 : mem_q[rd_ptr_q];
  assign stop_req  = stop_req_q;
  assign irq       = irq_en_q & empty_s;

endmodule

// File: tb/tb_ahb_tty_fifo.sv
// Directed self-checking bench for ahb_tty_fifo (single slave, HREADY
// looped back from HREADYOUT). Inputs change 1ns after the rising edge and
// outputs are sampled 2ns after it.
module tb_ahb_tty_fifo;

  logic        HCLK     = 1'b0;
  logic        HRESET   = 1'b1;
  logic        HSEL     = 1'b0;
  logic [3:0]  HADDR    = 4'h0;
  logic [1:0]  HTRANS   = 2'b00;
  logic        HWRITE   = 1'b0;
  logic [2:0]  HSIZE    = 3'd2;
  logic [31:0] HWDATA   = 32'h0;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        stop_req;
  logic        irq;

  int checks   = 0;
  int failures = 0;
  logic [7:0] got[$];

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahb_tty_fifo #(.DEPTH_LOG2(3), .STOP_CHAR(8'h0D)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .stop_req(stop_req), .irq(irq)
  );

  // Record every byte the sink accepts (handshake completes at next rise).
  always @(negedge HCLK) begin
    if (!HRESET && tx_valid && tx_ready) got.push_back(tx_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Address phase then data phase; returns with the data phase about to
  // complete at the next rising edge. waits = stalled cycles seen.
  task automatic wr(input logic [3:0] a, input logic [31:0] d, output int waits);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HADDR = a; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    #1;
    waits = 0;
    while (!HREADYOUT && waits < 40) begin
      @(posedge HCLK); #2;
      waits++;
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [2:0] sz,
                    output logic [31:0] d, output logic rdy, output logic rsp);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HADDR = a; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = sz;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HSIZE = 3'd2;
    #1;
    d = HRDATA; rdy = HREADYOUT; rsp = HRESP;
  endtask

  // Begin a DATA write that is expected to stall; returns in its data phase.
  task automatic start_stalled_write(input logic [31:0] d);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HADDR = 4'h0; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    #1;
  endtask

  initial begin
    int          w;
    logic [31:0] d;
    logic        rdy;
    logic        rsp;

    // ---- reset ----
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    #1;
    chk("rst_hreadyout", HREADYOUT, 32'd1);
    chk("rst_hresp",     HRESP,     32'd0);
    chk("rst_hrdata",    HRDATA,    32'd0);
    chk("rst_tx_valid",  tx_valid,  32'd0);
    chk("rst_tx_data",   tx_data,   32'd0);
    chk("rst_stop_req",  stop_req,  32'd0);
    chk("rst_irq",       irq,       32'd0);

    // ---- ordered drain, no fall-through ----
    tx_ready = 1'b1;
    wr(4'h0, 32'h41, w);
    chk("t1_wait0", w, 32'd0);
    chk("t1_no_fallthrough", tx_valid, 32'd0);
    chk("t1_hrdata_in_write", HRDATA, 32'd0);
    wr(4'h0, 32'h42, w);
    wr(4'h0, 32'h43, w);
    repeat (4) @(posedge HCLK); #2;
    chk("t1_count", got.size(), 32'd3);
    chk("t1_byte0", got[0], 32'h41);
    chk("t1_byte1", got[1], 32'h42);
    chk("t1_byte2", got[2], 32'h43);
    rd(4'h4, 3'd2, d, rdy, rsp);
    chk("t1_status", d, 32'h1);
    chk("t1_status_rdy", rdy, 32'd1);
    chk("t1_status_rsp", rsp, 32'd0);

    // ---- fill, stall on 9th, accept on pop, wrap ----
    tx_ready = 1'b0;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      wr(4'h0, 32'h10 + i, w);
      chk("t2_fill_wait0", w, 32'd0);
    end
    rd(4'h4, 3'd2, d, rdy, rsp);
    chk("t2_status_full", d, 32'h0802);
    start_stalled_write(32'h18);
    chk("t2_stall", HREADYOUT, 32'd0);
    repeat (2) @(posedge HCLK); #2;
    chk("t2_stall_hold", HREADYOUT, 32'd0);
    tx_ready = 1'b1;
    #1;
    chk("t2_accept_on_pop", HREADYOUT, 32'd1);
    @(posedge HCLK); #1;
    tx_ready = 1'b0;
    rd(4'h4, 3'd2, d, rdy, rsp);
    chk("t2_status_still_full", d, 32'h0802);
    tx_ready = 1'b1;
    repeat (12) @(posedge HCLK); #2;
    chk("t2_drained", got.size(), 32'd9);
    for (int i = 0; i < 9; i++) chk("t2_order", got[i], 32'h10 + i);
    rd(4'h4, 3'd2, d, rdy, rsp);
    chk("t2_status_empty", d, 32'h1);

    // ---- error responses ----
    rd(4'hC, 3'd2, d, rdy, rsp);
    chk("t3_err_c_rdy1", rdy, 32'd0);
    chk("t3_err_c_rsp1", rsp, 32'd1);
    @(posedge HCLK); #2;
    chk("t3_err_c_rdy2", HREADYOUT, 32'd1);
    chk("t3_err_c_rsp2", HRESP, 32'd1);
    rd(4'h2, 3'd2, d, rdy, rsp);
    chk("t3_err_unal_rdy1", rdy, 32'd0);
    chk("t3_err_unal_rsp1", rsp, 32'd1);
    @(posedge HCLK); #2;
    chk("t3_err_unal_rdy2", HREADYOUT, 32'd1);
    chk("t3_err_unal_rsp2", HRESP, 32'd1);
    rd(4'h8, 3'd2, d, rdy, rsp);
    chk("t3_ctrl_unchanged", d, 32'h0);
    chk("t3_ok_after_err", rsp, 32'd0);
    rd(4'h4, 3'd2, d, rdy, rsp);
    chk("t3_status_unchanged", d, 32'h1);

    // ---- interrupt ----
    wr(4'h8, 32'h1, w);
    @(posedge HCLK); #2;
    chk("t4_irq_empty", irq, 32'd1);
    rd(4'h8, 3'd2, d, rdy, rsp);
    chk("t4_ctrl_read", d, 32'h1);
    tx_ready = 1'b0;
    wr(4'h0, 32'h55, w);
    @(posedge HCLK); #2;
    chk("t4_irq_queued", irq, 32'd0);
    chk("t4_tx_data", tx_data, 32'h55);
    tx_ready = 1'b1;
    repeat (3) @(posedge HCLK); #2;
    chk("t4_irq_drained", irq, 32'd1);
    wr(4'h8, 32'h0, w);
    @(posedge HCLK); #2;
    chk("t4_irq_disabled", irq, 32'd0);

    // ---- stop character ----
    got.delete();
    wr(4'h0, 32'h0D, w);
    chk("t5_stop_wait0", w, 32'd0);
    chk("t5_stop_not_yet", stop_req, 32'd0);
    @(posedge HCLK); #2;
    chk("t5_stop_set", stop_req, 32'd1);
    wr(4'h0, 32'h44, w);
    chk("t5_discard_wait0", w, 32'd0);
    repeat (3) @(posedge HCLK); #2;
    chk("t5_nothing_sent", got.size(), 32'd0);
    chk("t5_tx_valid", tx_valid, 32'd0);
    rd(4'h4, 3'd2, d, rdy, rsp);
    chk("t5_status", d, 32'h5);

    // ---- reset during a full-FIFO stall ----
    @(posedge HCLK); #1 HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    #1;
    chk("t6_stop_cleared", stop_req, 32'd0);
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(4'h0, 32'h60 + i, w);
    start_stalled_write(32'h68);
    chk("t6_stall", HREADYOUT, 32'd0);
    #1;
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    #1;
    chk("t6_hreadyout", HREADYOUT, 32'd1);
    chk("t6_hresp", HRESP, 32'd0);
    chk("t6_tx_valid", tx_valid, 32'd0);
    rd(4'h4, 3'd2, d, rdy, rsp);
    chk("t6_status", d, 32'h1);

    @(posedge HCLK); #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
